ccip_host_mem_responder: RTL
============================

# ccip_host_mem_responder

Simulation-grade CCI-P host-memory responder: it plays the FIU/host end of the channels an AFU requestor drives. It accepts c0 read and c1 write/fence requests, serves them from an internal cache-line array mapped at a fixed physical window, and returns fixed-latency `ccip_rx` responses. Benches instantiate it in place of the shim/MPF stack so requestors and accelerator datapaths can be exercised standalone.

## Interface
Parameters:
- `DEPTH_CL`, 64: cache lines backed; power of two, ≥2.
- `BASE_CL`, 0: first cache-line address (t_ccip_clAddr units) of the window.
- `RD_LATENCY`, 8: request-to-response cycles on c0; ≥1.
- `WR_LATENCY`, 4: request-to-response cycles on c1; ≥1.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `ccip_c0_tx` in t_if_ccip_c0_Tx: read requests.
- `ccip_c1_tx` in t_if_ccip_c1_Tx: write and fence requests.
- `ccip_rx` out t_if_ccip_Rx: responses and almost-full flags.
- `stall_c0`, `stall_c1` in 1: bench knobs; drive `c0TxAlmFull`/`c1TxAlmFull`.
- `load_valid` in 1, `load_idx` in $clog2(DEPTH_CL), `load_data` in t_ccip_clData: backdoor preload.
- `err_count` out 16: saturating count of rejected requests.

## Operation
- Index = `hdr.address - BASE_CL`. In window: 0 ≤ index < DEPTH_CL.
- c0 `valid` with `req_type` eREQ_RDLINE_I/S, `cl_len` eCL_LEN_1, in window: read array in the acceptance cycle; response carries `resp_type` eRSP_RDLINE, echoed `mdata`, `cl_num` 0, `vc_used` eVC_VL0, `hit_miss` 0, data.
- c1 `valid` with eREQ_WRLINE_I/M, eCL_LEN_1, `sop` 1, in window: write array in the acceptance cycle; response eRSP_WRLINE, echoed `mdata`, `format` 0, `cl_num` 0.
- c1 eREQ_WRFENCE: no array access; response eRSP_WRFENCE, echoed `mdata`, on the same pipeline. All earlier write responses therefore precede it.
- Rejected requests get no response, no array access, and `err_count`+1, saturating at 16'hFFFF. Causes: out of window, `cl_len` ≠ eCL_LEN_1, or unsupported `req_type`. A c0 and a c1 rejection in the same cycle add 2.
- Same-cycle c0 read and c1 write to the same index: the read returns the old data (read-first).
- Same-cycle `load_valid` and accepted c1 write to the same index: the c1 write wins. Different indices: both commit.
- `c0.mmioRdValid`, `c0.mmioWrValid` are constant 0. c2 Tx is ignored.
- `c0TxAlmFull`/`c1TxAlmFull` are registered copies of `stall_c0`/`stall_c1`. Requests arriving while a flag is high are still accepted; there is no internal backpressure.

## Timing
- Request valid in cycle k → `c0.rspValid` in cycle k+RD_LATENCY, `c1.rspValid` in cycle k+WR_LATENCY.
- One request per channel per cycle. Responses keep request order. Throughput is one per cycle per channel.
- Each response is valid for exactly one cycle. c0 and c1 responses may coincide.
- Almost-full flags lag the stall inputs by 1 cycle.
- Reset:
  - Every `ccip_rx` field resets to 0, `err_count` to 0, and both delay lines clear. In-flight responses are dropped, never emitted.
  - Array contents are not reset.
  - Requests presented in the reset cycle are ignored.
  - The first request is accepted in the cycle after `reset` deasserts.

## Structure
- Package `ccip_host_mem_pkg`:
  - `t_hm_c0_rsp` = {valid, t_ccip_c0_RspMemHdr, t_ccip_clData}.
  - `t_hm_c1_rsp` = {valid, t_ccip_c1_RspMemHdr}.
  - Decode helpers `hm_in_window()` and `hm_c0_supported()`/`hm_c1_supported()`.
- Sub-module `ccip_host_mem_delay_line`: parameterized LATENCY and payload type. Shift register, valid cleared on reset, payload not reset. Instantiated once per channel.
- Top: array, decode, error counter, almost-full registers, Rx assembly.

## Test plan
- Preload idx 3 = 512'hA5…A5; c0 RDLINE_I addr BASE_CL+3, mdata 16'h0042 → `c0.rspValid` exactly 8 cycles later, eRSP_RDLINE, mdata 16'h0042, data A5…A5.
- c1 WRLINE_I idx 5 data 512'h1234, mdata 7; c0 read idx 5 in the next cycle → c1 rsp eRSP_WRLINE mdata 7 at +4; c0 returns 512'h1234 at +8.
- Same-cycle read+write idx 9 (old 0, new 1) → read returns 0; a later read returns 1.
- Four back-to-back writes mdata 1–4, then WRFENCE mdata 5 → responses 1,2,3,4,5 on consecutive cycles, the fence as eRSP_WRFENCE.
- Read addr BASE_CL+DEPTH_CL plus a cl_len eCL_LEN_2 write in the same cycle → no responses; `err_count` 0→2. Force to 16'hFFFF and add one → stays 16'hFFFF.
- Issue 3 reads, assert `reset` 2 cycles later for 1 cycle → no `rspValid` ever emitted; array data intact on a re-read; `stall_c1`=1 shows on `c1TxAlmFull` 1 cycle later.

Source files
------------

// File: rtl/ccip_host_mem_pkg.sv
// Types and decode helpers shared by the CCI-P host-memory responder.
// Holds the CCI-P subset the responder speaks: request and response
// headers, channel bundles, and the delay-line payloads.
package ccip_host_mem_pkg;

    localparam int CL_DATA_W = 512;
    localparam int CL_ADDR_W = 42;
    localparam int MDATA_W   = 16;

    typedef logic [CL_ADDR_W-1:0] t_ccip_clAddr;
    typedef logic [CL_DATA_W-1:0] t_ccip_clData;
    typedef logic [MDATA_W-1:0]   t_ccip_mdata;
    typedef logic [1:0]           t_ccip_clNum;

    typedef enum logic [1:0] {
        eVC_VA  = 2'h0,
        eVC_VL0 = 2'h1,
        eVC_VH0 = 2'h2,
        eVC_VH1 = 2'h3
    } t_ccip_vc;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'h0,
        eCL_LEN_2 = 2'h1,
        eCL_LEN_4 = 2'h3
    } t_ccip_clLen;

    typedef enum logic [3:0] {
        eREQ_RDLINE_I = 4'h0,
        eREQ_RDLINE_S = 4'h1
    } t_ccip_c0_req;

    typedef enum logic [3:0] {
        eREQ_WRLINE_I = 4'h0,
        eREQ_WRLINE_M = 4'h1,
        eREQ_WRPUSH_I = 4'h2,
        eREQ_WRFENCE  = 4'h4,
        eREQ_INTR     = 4'h6
    } t_ccip_c1_req;

    typedef enum logic [3:0] {
        eRSP_RDLINE = 4'h0,
        eRSP_UMSG   = 4'h4
    } t_ccip_c0_rsp;

    typedef enum logic [3:0] {
        eRSP_WRLINE  = 4'h0,
        eRSP_WRFENCE = 4'h4,
        eRSP_INTR    = 4'h6
    } t_ccip_c1_rsp;

    typedef struct packed {
        t_ccip_vc     vc_sel;
        logic [1:0]   rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c0_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        logic [5:0]   rsvd2;
        t_ccip_vc     vc_sel;
        logic         sop;
        logic         rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c1_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        t_ccip_vc     vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic [1:0]   rsvd0;
        t_ccip_clNum  cl_num;
        t_ccip_c0_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c0_RspMemHdr;

    typedef struct packed {
        t_ccip_vc     vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic         format;
        logic         rsvd0;
        t_ccip_clNum  cl_num;
        t_ccip_c1_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c1_RspMemHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        t_ccip_clData       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        t_ccip_clData       data;
        logic               rspValid;
        logic               mmioRdValid;
        logic               mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_ccip_c1_RspMemHdr hdr;
        logic               rspValid;
    } t_if_ccip_c1_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
        t_if_ccip_c1_Rx c1;
    } t_if_ccip_Rx;

    // Delay-line payloads: a response plus its valid flag.
    typedef struct packed {
        logic               valid;
        t_ccip_c0_RspMemHdr hdr;
        t_ccip_clData       data;
    } t_hm_c0_rsp;

    typedef struct packed {
        logic               valid;
        t_ccip_c1_RspMemHdr hdr;
    } t_hm_c1_rsp;

    // True when addr falls in [base, base + depth). Addresses below base
    // wrap to a huge offset and fail the compare.
    function automatic logic hm_in_window(input t_ccip_clAddr addr,
                                          input t_ccip_clAddr base,
                                          input t_ccip_clAddr depth);
        t_ccip_clAddr offset;
        offset = addr - base;
        return offset < depth;
    endfunction

    // Single-line reads of either flavour are the only c0 requests served.
    function automatic logic hm_c0_supported(input t_ccip_c0_req req_type,
                                             input t_ccip_clLen  cl_len);
        return (req_type == eREQ_RDLINE_I || req_type == eREQ_RDLINE_S) &&
               (cl_len == eCL_LEN_1);
    endfunction

    // Fences are always served; writes must be single-line, start-of-packet.
    function automatic logic hm_c1_supported(input t_ccip_c1_req req_type,
                                             input t_ccip_clLen  cl_len,
                                             input logic         sop);
        if (req_type == eREQ_WRFENCE) begin
            return 1'b1;
        end
        return (req_type == eREQ_WRLINE_I || req_type == eREQ_WRLINE_M) &&
               (cl_len == eCL_LEN_1) && sop;
    endfunction

endpackage

// File: rtl/ccip_host_mem_delay_line.sv
// Fixed-latency shift register for one response channel. The valid bit
// per stage is cleared by reset so in-flight responses are dropped; the
// payload stages are plain data and keep whatever they held.
module ccip_host_mem_delay_line
    import ccip_host_mem_pkg::*;
#(
    parameter int  LATENCY = 1,
    parameter type T       = t_hm_c1_rsp
) (
    input  logic clk,
    input  logic reset,
    input  T     in_i,
    output T     out_o
);

    logic [LATENCY-1:0] vld_q;
    T                   pay_q [LATENCY];

    // Shift the valid flags; reset empties the pipeline.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with <= so every stage samples the value its
        // neighbour held before this edge, giving a true shift register.
        if (reset) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= in_i.valid;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Shift the payloads alongside the valid flags.
    always_ff @(posedge clk) begin
        // NOTE: wide data storage gets no reset; its contents only matter
        // when the matching valid flag is set, and that flag is reset.
        pay_q[0] <= in_i;
        for (int i = 1; i < LATENCY; i++) begin
            pay_q[i] <= pay_q[i-1];
        end
    end

    // Present the last stage with its reset-clean valid flag.
    always_comb begin
        // NOTE: out_o is fully assigned before any field override, so no
        // path leaves it holding a previous value and no latch is inferred.
        out_o       = pay_q[LATENCY-1];
        out_o.valid = vld_q[LATENCY-1];
    end

endmodule

// File: rtl/ccip_host_mem_responder.sv
// CCI-P host-memory responder: serves c0 reads and c1 writes/fences from
// a cache-line array mapped at BASE_CL, returning fixed-latency responses.
module ccip_host_mem_responder
    import ccip_host_mem_pkg::*;
#(
    parameter int           DEPTH_CL   = 64,
    parameter t_ccip_clAddr BASE_CL    = '0,
    parameter int           RD_LATENCY = 8,
    parameter int           WR_LATENCY = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  t_if_ccip_c0_Tx              ccip_c0_tx,
    input  t_if_ccip_c1_Tx              ccip_c1_tx,
    output t_if_ccip_Rx                 ccip_rx,
    input  logic                        stall_c0,
    input  logic                        stall_c1,
    input  logic                        load_valid,
    input  logic [$clog2(DEPTH_CL)-1:0] load_idx,
    input  t_ccip_clData                load_data,
    output logic [15:0]                 err_count
);

    localparam int IDX_W = $clog2(DEPTH_CL);

    t_ccip_clData mem_q [DEPTH_CL];

    logic [IDX_W-1:0] c0_idx;
    logic [IDX_W-1:0] c1_idx;
    logic             c0_req;
    logic             c0_acc;
    logic             c0_rej;
    logic             c1_req;
    logic             c1_is_fence;
    logic             c1_acc;
    logic             c1_wr_acc;
    logic             c1_rej;

    logic [15:0]      err_count_q;
    logic [15:0]      err_count_d;
    logic [16:0]      err_sum;
    logic             c0_alm_full_q;
    logic             c1_alm_full_q;

    t_hm_c0_rsp       c0_rsp_in;
    t_hm_c0_rsp       c0_rsp_out;
    t_hm_c1_rsp       c1_rsp_in;
    t_hm_c1_rsp       c1_rsp_out;

    // Header fields a host-memory model has no use for (VC selection and
    // reserved bits) are folded here to make that choice explicit.
    logic unused_hdr_bits;
    assign unused_hdr_bits = ^{ccip_c0_tx.hdr.vc_sel, ccip_c0_tx.hdr.rsvd1,
                               ccip_c0_tx.hdr.rsvd0, ccip_c1_tx.hdr.rsvd2,
                               ccip_c1_tx.hdr.vc_sel, ccip_c1_tx.hdr.rsvd1,
                               ccip_c1_tx.hdr.rsvd0};

    // Decode: a request in the reset cycle is neither served nor counted.
    always_comb begin
        c0_idx      = IDX_W'(ccip_c0_tx.hdr.address - BASE_CL);
        c1_idx      = IDX_W'(ccip_c1_tx.hdr.address - BASE_CL);
        c0_req      = ccip_c0_tx.valid && !reset;
        c1_req      = ccip_c1_tx.valid && !reset;
        c0_acc      = c0_req &&
                      hm_c0_supported(ccip_c0_tx.hdr.req_type, ccip_c0_tx.hdr.cl_len) &&
                      hm_in_window(ccip_c0_tx.hdr.address, BASE_CL, t_ccip_clAddr'(DEPTH_CL));
        c1_is_fence = (ccip_c1_tx.hdr.req_type == eREQ_WRFENCE);
        c1_acc      = c1_req &&
                      hm_c1_supported(ccip_c1_tx.hdr.req_type, ccip_c1_tx.hdr.cl_len,
                                      ccip_c1_tx.hdr.sop) &&
                      (c1_is_fence ||
                       hm_in_window(ccip_c1_tx.hdr.address, BASE_CL, t_ccip_clAddr'(DEPTH_CL)));
        c1_wr_acc   = c1_acc && !c1_is_fence;
        c0_rej      = c0_req && !c0_acc;
        c1_rej      = c1_req && !c1_acc;
    end

    // Cache-line array; the c1 write is last so it wins over a same-index preload.
    always_ff @(posedge clk) begin
        if (load_valid) begin
            mem_q[load_idx] <= load_data;
        end
        if (c1_wr_acc) begin
            mem_q[c1_idx] <= ccip_c1_tx.data;
        end
    end

    // Build responses in the acceptance cycle; the read sees pre-write data.
    always_comb begin
        c0_rsp_in                = '0;
        c0_rsp_in.valid          = c0_acc;
        c0_rsp_in.hdr.vc_used    = eVC_VL0;
        c0_rsp_in.hdr.resp_type  = eRSP_RDLINE;
        c0_rsp_in.hdr.mdata      = ccip_c0_tx.hdr.mdata;
        c0_rsp_in.data           = mem_q[c0_idx];

        c1_rsp_in                = '0;
        c1_rsp_in.valid          = c1_acc;
        c1_rsp_in.hdr.vc_used    = eVC_VL0;
        c1_rsp_in.hdr.resp_type  = c1_is_fence ? eRSP_WRFENCE : eRSP_WRLINE;
        c1_rsp_in.hdr.mdata      = ccip_c1_tx.hdr.mdata;
    end

    ccip_host_mem_delay_line #(
        .LATENCY (RD_LATENCY),
        .T       (t_hm_c0_rsp)
    ) u_c0_delay (
        .clk   (clk),
        .reset (reset),
        .in_i  (c0_rsp_in),
        .out_o (c0_rsp_out)
    );

    // Fences share the write pipeline, so they trail every earlier write response.
    ccip_host_mem_delay_line #(
        .LATENCY (WR_LATENCY),
        .T       (t_hm_c1_rsp)
    ) u_c1_delay (
        .clk   (clk),
        .reset (reset),
        .in_i  (c1_rsp_in),
        .out_o (c1_rsp_out)
    );

    // Saturating rejection count; both channels may reject in one cycle.
    always_comb begin
        err_sum     = {1'b0, err_count_q} + 17'(c0_rej) + 17'(c1_rej);
        err_count_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    // Error counter and almost-full flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count_q   <= '0;
            c0_alm_full_q <= 1'b0;
            c1_alm_full_q <= 1'b0;
        end else begin
            err_count_q   <= err_count_d;
            c0_alm_full_q <= stall_c0;
            c1_alm_full_q <= stall_c1;
        end
    end

    assign err_count = err_count_q;

    // Rx assembly; idle response fields are forced to zero.
    always_comb begin
        ccip_rx             = '0;
        ccip_rx.c0TxAlmFull = c0_alm_full_q;
        ccip_rx.c1TxAlmFull = c1_alm_full_q;
        if (c0_rsp_out.valid) begin
            ccip_rx.c0.hdr      = c0_rsp_out.hdr;
            ccip_rx.c0.data     = c0_rsp_out.data;
            ccip_rx.c0.rspValid = 1'b1;
        end
        if (c1_rsp_out.valid) begin
            ccip_rx.c1.hdr      = c1_rsp_out.hdr;
            ccip_rx.c1.rspValid = 1'b1;
        end
    end

endmodule
